// File: rtl/imem_loader.sv
// Purpose: loads a length-prefixed big-endian byte stream into instruction memory while holding the CPU.
// Latency: mem_we pulses one cycle after the 4th byte of a word is accepted; minimum 5 cycles per word.
// Backpressure: in_ready drops in IDLE/WRITE/DONE/ERR; the source must hold its byte until accepted.
module imem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] remaining;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic        xfer;
  logic        restart;
  logic [15:0] len_full;

  assign xfer      = in_valid & in_ready;
  assign len_full  = {len_hi, in_data};
  assign restart   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign mem_wdata = asm_word;

  // State register; reset abandons any load in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)         state_nxt = S_DONE;
          else if (len_full > DEPTH16)   state_nxt = S_ERR;
          else                           state_nxt = S_DATA;
        end
      end
      S_DATA:  if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (remaining == 16'd1) ? S_DONE : S_DATA;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state so they are stable for the whole cycle
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Length capture, word assembly and write-address/remaining bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi    <= 8'd0;
      remaining <= 16'd0;
      byte_idx  <= 2'd0;
      asm_word  <= 32'd0;
      mem_addr  <= BASE_ADDR;
    end else begin
      if (restart) begin
        mem_addr <= BASE_ADDR;
        byte_idx <= 2'd0;
      end
      case (state)
        S_LEN_HI: if (xfer) len_hi <= in_data;
        S_LEN_LO: begin
          if (xfer) begin
            remaining <= len_full;
            byte_idx  <= 2'd0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            asm_word <= {asm_word[23:0], in_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + 32'd4;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader; the writing side of the instruction memory that the datapath reads through the PC.
- Accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses.
- Asserts cpu_hold while loading so the PC and register bank stay frozen until the image is complete.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; legal range 1..65535.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- mem_we  output  1  one-cycle instruction memory write strobe.
- mem_addr  output  32  byte address for the write.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  stall for the PC/datapath.
- done  output  1  level: last load completed successfully.
- error  output  1  level: last load rejected because it was too long.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs 0, mem_addr=BASE_ADDR, internal word count and byte index cleared.
  - A reset in the middle of a load abandons it. The partial image stays in memory, no further writes occur, and cpu_hold drops immediately.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Go to LEN_HI.
  - Clear done and error, set cpu_hold=1, mem_addr=BASE_ADDR.
  - start in any other state is ignored.
- LEN_HI: in_ready=1. On a transfer, capture the byte as len[15:8] and go to LEN_LO.
- LEN_LO: in_ready=1. On a transfer, capture len[7:0], then:
  - len==0: go to DONE.
  - len>DEPTH_WORDS: go to ERR.
  - otherwise: go to DATA with byte index 0 and remaining=len.
- DATA: in_ready=1.
  - Each transfer shifts the byte into an assembly register. The first byte lands in [31:24] (big-endian).
  - On the 4th transfer, go to WRITE.
  - Cycles with in_valid=0 are stalls: no state change.
- WRITE: in_ready=0, mem_we=1 for exactly this cycle, mem_wdata=assembled word, mem_addr=current address. On the next edge:
  - mem_addr+=4 (32-bit wrap, no saturation).
  - remaining-=1.
  - If remaining reaches 0, go to DONE; else go to DATA.
- Latency: mem_we asserts on the cycle immediately after the edge that accepted the 4th byte. The minimum is 5 cycles per word.
- DONE: cpu_hold=0, done=1, in_ready=0. Held until start or reset.
- ERR: cpu_hold=0, error=1, in_ready=0. No memory writes occurred. Held until start or reset.
- in_ready is 0 in IDLE, WRITE, DONE and ERR. Bytes presented there are not consumed; the source must hold them.
- mem_we is never asserted outside WRITE.
- mem_wdata and mem_addr are don't-care when mem_we=0, but must be stable during WRITE.
- done and error are never 1 simultaneously.
- Boundary conditions:
  - len==DEPTH_WORDS is legal; the final write address is BASE_ADDR+4*(DEPTH_WORDS-1).
  - start asserted in the same cycle as the DONE entry edge is ignored; it is only sampled once the loader is in DONE.

Test Plan:
- Reset with rst_n=0 → in_ready=0, mem_we=0, cpu_hold=0, done=0, error=0, mem_addr=0.
- start, then bytes 00 02 20 08 00 05 AC 09 00 10 with in_valid always 1 → two writes: addr 0x0 data 0x20080005, addr 0x4 data 0xAC090010. Then done=1, cpu_hold=0. cpu_hold=1 from the cycle after start until DONE.
- Same stream with in_valid toggled 1/0 every cycle → identical writes and order. in_ready=0 on each WRITE cycle, and no byte is dropped or duplicated.
- start, bytes 00 00 → DONE after 2 transfers, no mem_we pulse, done=1.
- DEPTH_WORDS=256, length bytes 01 01 (257) → ERR, error=1, cpu_hold=0, zero writes, in_ready=0 afterwards.
- rst_n pulsed low after 2 data bytes of the first word of a 3-word load → outputs return to reset values asynchronously, no write. A subsequent start plus a 1-word stream writes to addr 0x0 correctly.
